// File: rtl/mem_write_scheduler_if.sv
// Write-path bundle between the two requesters, the RAM write port and the output-port consumer.
interface mem_write_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_gnt;
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_data;
  logic              ldr_gnt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] port_data;
  logic              port_valid;
  logic              port_ready;
  logic              fifo_full;
  logic              busy;

  modport master (
    output cpu_req, cpu_addr, cpu_data, ldr_req, ldr_addr, ldr_data, port_ready,
    input  cpu_gnt, ldr_gnt, ram_we, ram_addr, ram_data, port_data, port_valid,
           fifo_full, busy
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_data, ldr_req, ldr_addr, ldr_data, port_ready,
    output cpu_gnt, ldr_gnt, ram_we, ram_addr, ram_data, port_data, port_valid,
           fifo_full, busy
  );
endinterface

// File: rtl/mem_write_scheduler.sv
// Round-robin arbiter for CPU/loader writes; RAM writes are registered (1 cycle),
// output-port writes go through a small FIFO drained by valid/ready.
module mem_write_scheduler #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] PORT_ADDR  = 8'h00,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  mem_write_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RR_CPU = 1'b0, RR_LDR = 1'b1} rr_e;

  rr_e               r_rr;
  rr_e               w_rr_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;

  logic              w_full;
  logic              w_empty;
  logic              w_cpu_port;
  logic              w_ldr_port;
  logic              w_cpu_elig;
  logic              w_ldr_elig;
  logic              w_cpu_gnt;
  logic              w_ldr_gnt;
  logic              w_gnt_any;
  logic              w_sel_port;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_push;
  logic              w_pop;
  logic              w_ram_wr;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_cpu_port = (bus.cpu_addr == PORT_ADDR);
  assign w_ldr_port = (bus.ldr_addr == PORT_ADDR);

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_cpu_elig = !RST && bus.cpu_req && (!w_cpu_port || !w_full);
  assign w_ldr_elig = !RST && bus.ldr_req && (!w_ldr_port || !w_full);

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ldr_gnt = 1'b0;
    w_rr_nxt  = r_rr;
    if (w_cpu_elig && (!w_ldr_elig || r_rr == RR_CPU)) begin
      w_cpu_gnt = 1'b1;
      w_rr_nxt  = RR_LDR;
    end else if (w_ldr_elig) begin
      w_ldr_gnt = 1'b1;
      w_rr_nxt  = RR_CPU;
    end
  end

  assign w_gnt_any  = w_cpu_gnt | w_ldr_gnt;
  assign w_sel_port = w_ldr_gnt ? w_ldr_port : w_cpu_port;
  assign w_sel_addr = w_ldr_gnt ? bus.ldr_addr : bus.cpu_addr;
  assign w_sel_data = w_ldr_gnt ? bus.ldr_data : bus.cpu_data;
  assign w_push     = w_gnt_any & w_sel_port;
  assign w_ram_wr   = w_gnt_any & !w_sel_port;
  assign w_pop      = !w_empty & bus.port_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr       <= RR_CPU;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_rr     <= w_rr_nxt;
      r_ram_we <= w_ram_wr;
      if (w_ram_wr) begin
        r_ram_addr <= w_sel_addr;
        r_ram_data <= w_sel_data;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_sel_data;
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.ldr_gnt    = w_ldr_gnt;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_data   = r_ram_data;
  assign bus.port_data  = r_mem[r_rd_ptr];
  assign bus.port_valid = !w_empty;
  assign bus.fifo_full  = w_full;
  assign bus.busy       = bus.cpu_req | bus.ldr_req | !w_empty;
endmodule
